// File: rtl/aud_play_ctrl.sv
// Playback controller: arbitrates stream/alert FIFOs onto the PWM read port,
// sequences start/stop/flush, applies mute/pause and tracks underrun and word counts.
module aud_play_ctrl #(
  parameter int                         FIFO_DATA_WIDTH = 32,
  parameter int                         UNDERRUN_CYCLES = 1024,
  parameter logic [FIFO_DATA_WIDTH-1:0] MUTE_WORD       = 32'h80808080
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       pause,
  input  logic                       mute,
  input  logic                       alert_en,
  input  logic                       flush,
  input  logic                       clear_status,
  input  logic [FIFO_DATA_WIDTH-1:0] stream_rd_data,
  input  logic                       stream_empty,
  output logic                       stream_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0] alert_rd_data,
  input  logic                       alert_empty,
  output logic                       alert_rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] out_rd_data,
  output logic                       out_empty,
  input  logic                       out_rd_en,
  output logic [1:0]                 state,
  output logic                       underrun,
  output logic [15:0]                underrun_count,
  output logic [31:0]                word_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_ALERT  = 2'b10,
    ST_FLUSH  = 2'b11
  } state_t;

  localparam int RUN_W = (UNDERRUN_CYCLES > 1) ? $clog2(UNDERRUN_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(UNDERRUN_CYCLES - 1);

  state_t               state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 underrun_q, underrun_d;
  logic [15:0]          urun_cnt_q, urun_cnt_d;
  logic [31:0]          word_cnt_q, word_cnt_d;

  logic                       sel_empty;
  logic [FIFO_DATA_WIDTH-1:0] sel_data;
  logic                       active;
  logic                       pop;

  // Read-port mux, driven only from the registered state.
  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    case (state_q)
      ST_STREAM: begin
        sel_empty = stream_empty;
        sel_data  = stream_rd_data;
      end
      ST_ALERT: begin
        sel_empty = alert_empty;
        sel_data  = alert_rd_data;
      end
      default: ;
    endcase
    active       = (state_q == ST_STREAM) || (state_q == ST_ALERT);
    out_empty    = !active || sel_empty || pause;
    out_rd_data  = !active ? '0 : (mute ? MUTE_WORD : sel_data);
    pop          = out_rd_en && !out_empty;
    stream_rd_en = ((state_q == ST_STREAM) && pop) || ((state_q == ST_FLUSH) && !stream_empty);
    alert_rd_en  = (state_q == ST_ALERT) && pop;
  end

  // Next state: stop beats flush beats start; pause freezes everything but stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!stop && !pause) begin
          if (flush)
            state_d = ST_FLUSH;
          else if (start)
            state_d = (alert_en && !alert_empty) ? ST_ALERT : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (stop)
          state_d = ST_IDLE;
        else if (!pause && alert_en && !alert_empty)
          state_d = ST_ALERT;
      end
      ST_ALERT: begin
        if (stop)
          state_d = ST_IDLE;
        else if (!pause && (alert_empty || !alert_en))
          state_d = ST_STREAM;
      end
      ST_FLUSH: begin
        if (stream_empty)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run_d      = run_q;
    underrun_d = underrun_q;
    urun_cnt_d = urun_cnt_q;
    word_cnt_d = word_cnt_q;

    if (pop && (word_cnt_q != '1))
      word_cnt_d = word_cnt_q + 32'd1;

    if ((state_q == ST_STREAM) && !pause) begin
      if (stream_empty) begin
        if (run_q == RUN_LAST) begin
          run_d      = '0;
          underrun_d = 1'b1;
          if (urun_cnt_q != '1)
            urun_cnt_d = urun_cnt_q + 16'd1;
        end else begin
          run_d = run_q + 1'b1;
        end
      end else begin
        run_d = '0;
      end
    end
    // The empty run only measures time spent continuously in STREAM.
    if (state_d != state_q)
      run_d = '0;

    if (clear_status) begin
      underrun_d = 1'b0;
      urun_cnt_d = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      run_q      <= '0;
      underrun_q <= 1'b0;
      urun_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      underrun_q <= underrun_d;
      urun_cnt_q <= urun_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign state          = state_q;
  assign underrun       = underrun_q;
  assign underrun_count = urun_cnt_q;
  assign word_count     = word_cnt_q;

endmodule

// File: tb/tb_aud_play_ctrl.sv
// Directed plus randomized bench for aud_play_ctrl; FIFOs are modelled as
// arrays here and a word-order scoreboard checks what reaches the PWM port.
module tb_aud_play_ctrl;
  localparam logic [31:0] MUTE = 32'h80808080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 0, stop = 0, pause = 0, mute = 0, alert_en = 0, flush = 0, clear_status = 0;
  logic [31:0] stream_rd_data, alert_rd_data, out_rd_data;
  logic        stream_empty, alert_empty, stream_rd_en, alert_rd_en, out_empty;
  logic        out_rd_en = 0;
  logic [1:0]  state;
  logic        underrun;
  logic [15:0] underrun_count;
  logic [31:0] word_count;

  logic [31:0] stream_mem [0:63];
  logic [31:0] alert_mem  [0:63];
  int s_head = 0, s_tail = 0, a_head = 0, a_tail = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign stream_empty   = (s_head == s_tail);
  assign stream_rd_data = stream_mem[s_head[5:0]];
  assign alert_empty    = (a_head == a_tail);
  assign alert_rd_data  = alert_mem[a_head[5:0]];

  always @(posedge clk) begin
    if (stream_rd_en && (s_head != s_tail)) s_head <= s_head + 1;
    if (alert_rd_en && (a_head != a_tail))  a_head <= a_head + 1;
  end

  aud_play_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .mute(mute),
    .alert_en(alert_en), .flush(flush), .clear_status(clear_status),
    .stream_rd_data(stream_rd_data), .stream_empty(stream_empty), .stream_rd_en(stream_rd_en),
    .alert_rd_data(alert_rd_data), .alert_empty(alert_empty), .alert_rd_en(alert_rd_en),
    .out_rd_data(out_rd_data), .out_empty(out_empty), .out_rd_en(out_rd_en),
    .state(state), .underrun(underrun), .underrun_count(underrun_count), .word_count(word_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_s(input logic [31:0] w);
    stream_mem[s_tail[5:0]] = w;
    s_tail = s_tail + 1;
  endtask

  task automatic push_a(input logic [31:0] w);
    alert_mem[a_tail[5:0]] = w;
    a_tail = a_tail + 1;
  endtask

  logic [31:0] exp_q [$];
  int          exp_wc;
  int          n_rd;
  logic        exp_empty;
  logic [31:0] w;

  initial begin
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_empty", 32'(out_empty), 32'd1);
    chk("rst_data", out_rd_data, 32'd0);
    chk("rst_rden", {30'd0, stream_rd_en, alert_rd_en}, 32'd0);
    chk("rst_cnt", {underrun, underrun_count, 15'd0} | word_count, 32'd0);
    rst = 0;
    tick();

    // Two stream words popped in order
    push_s(32'h11223344); push_s(32'h55667788);
    start = 1; tick(); start = 0; #1;
    chk("st_state", 32'(state), 32'd1);
    chk("st_data0", out_rd_data, 32'h11223344);
    out_rd_en = 1; #1;
    chk("st_rden0", 32'(stream_rd_en), 32'd1);
    tick();
    chk("st_data1", out_rd_data, 32'h55667788);
    chk("st_rden1", 32'(stream_rd_en), 32'd1);
    tick(); out_rd_en = 0; #1;
    chk("st_empty", 32'(out_empty), 32'd1);
    chk("st_wc", word_count, 32'd2);

    // Alert pre-emption, stream word must survive
    push_s(32'h12345678); push_a(32'hAAAAAAAA); alert_en = 1;
    tick();
    chk("al_state", 32'(state), 32'd2);
    chk("al_data", out_rd_data, 32'hAAAAAAAA);
    out_rd_en = 1; #1;
    chk("al_rden", {30'd0, stream_rd_en, alert_rd_en}, 32'd1);
    tick(); out_rd_en = 0;
    tick(); #1;
    chk("al_back", 32'(state), 32'd1);
    chk("al_sdata", out_rd_data, 32'h12345678);
    alert_en = 0; out_rd_en = 1; tick(); out_rd_en = 0; #1;
    chk("al_wc", word_count, 32'd4);
    chk("al_sempty", 32'(stream_empty), 32'd1);

    // Mute then pause
    push_s(32'h01020304); mute = 1; #1;
    chk("mu_data", out_rd_data, MUTE);
    out_rd_en = 1; #1;
    chk("mu_rden", 32'(stream_rd_en), 32'd1);
    tick(); out_rd_en = 0; mute = 0; #1;
    chk("mu_wc", word_count, 32'd5);
    push_s(32'h0BADF00D); pause = 1; out_rd_en = 1; #1;
    chk("pa_empty", 32'(out_empty), 32'd1);
    chk("pa_rden", 32'(stream_rd_en), 32'd0);
    tick();
    chk("pa_wc", word_count, 32'd5);
    pause = 0; #1;
    chk("pa_data", out_rd_data, 32'h0BADF00D);
    tick(); out_rd_en = 0; #1;
    chk("pa_wc2", word_count, 32'd6);

    // Underrun: restart STREAM so the empty run begins from a known edge
    stop = 1; tick(); stop = 0;
    start = 1; tick(); start = 0;
    repeat (1023) tick();
    chk("ur_before", {15'd0, underrun, underrun_count}, 32'd0);
    tick();
    chk("ur_first", {15'd0, underrun, underrun_count}, 32'h0001_0001);
    repeat (1024) tick();
    chk("ur_second", {15'd0, underrun, underrun_count}, 32'h0001_0002);
    clear_status = 1; tick(); clear_status = 0; #1;
    chk("ur_clear", {15'd0, underrun, underrun_count}, 32'd0);
    chk("wc_clear", word_count, 32'd0);

    // Flush five words from IDLE
    stop = 1; tick(); stop = 0;
    for (int i = 0; i < 5; i++) push_s(32'hF0000000 + 32'(i));
    flush = 1; tick(); flush = 0; #1;
    chk("fl_state", 32'(state), 32'd3);
    chk("fl_empty", 32'(out_empty), 32'd1);
    n_rd = 0;
    for (int i = 0; i < 12; i++) begin
      if (stream_rd_en) n_rd++;
      tick();
    end
    chk("fl_pops", 32'(n_rd), 32'd5);
    chk("fl_idle", 32'(state), 32'd0);
    chk("fl_wc", word_count, 32'd0);

    // stop+start+flush together in IDLE
    push_s(32'h77777777);
    stop = 1; start = 1; flush = 1; tick(); stop = 0; start = 0; flush = 0; #1;
    chk("pri_idle", 32'(state), 32'd0);
    flush = 1; tick(); flush = 0;
    repeat (4) tick();

    // Randomized STREAM traffic against a word-order scoreboard
    exp_wc = 0;
    start = 1; tick(); start = 0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_wc", word_count, 32'(exp_wc));
      if (($urandom_range(0, 1) == 1) && (exp_q.size() < 32)) begin
        w = $urandom;
        push_s(w);
        exp_q.push_back(w);
      end
      mute      = ($urandom_range(0, 3) == 0);
      pause     = ($urandom_range(0, 3) == 0);
      out_rd_en = ($urandom_range(0, 2) != 0);
      #1;
      exp_empty = pause || (exp_q.size() == 0);
      chk("rnd_empty", 32'(out_empty), 32'(exp_empty));
      if (!exp_empty) begin
        chk("rnd_data", out_rd_data, mute ? MUTE : exp_q[0]);
        if (out_rd_en) begin
          void'(exp_q.pop_front());
          exp_wc++;
        end
      end
      tick();
    end

    // Asynchronous reset mid-stream with a pop pending
    push_s(32'hCAFEF00D); pause = 0; mute = 0; out_rd_en = 1; #1;
    rst = 1; #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_empty", 32'(out_empty), 32'd1);
    chk("ar_rden", {30'd0, stream_rd_en, alert_rd_en}, 32'd0);
    tick();
    chk("ar_cnt", word_count | {underrun, underrun_count, 15'd0}, 32'd0);
    out_rd_en = 0; rst = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
